// File: rtl/stageif_pf.sv
// Instruction-fetch prefetch stage.
// Issues in-order fetch requests to instruction memory while the prefetch
// queue has credit, tags returning instructions with their PC, and presents
// the queue head to decode. A redirect flushes the queue and marks every
// outstanding request as stale, so its response is dropped when it returns.
//
// Ports:
//   i_clk, i_reset          clock (rising edge), synchronous active-low reset
//   i_redirect(_pc)         taken branch/jump from EX and its target
//   o_imem_req/addr         fetch request and address (combinational)
//   i_imem_gnt              request accepted this cycle
//   i_imem_rvalid/rdata     in-order response
//   o_valid, i_ready        decode handshake
//   o_instr, o_pc, o_pc_four  head instruction, its PC, PC+4
module stageif_pf #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_four
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] r_fpc;
  logic [XLEN-1:0] r_rpc;
  logic [CW-1:0]   r_inflight;
  logic [CW-1:0]   r_discard;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  entry_t          r_mem [DEPTH];

  logic [CW-1:0]   w_occ;
  logic [CW:0]     w_used;
  logic            w_gnt;
  logic            w_rsp;
  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_fpc_nxt;
  logic [XLEN-1:0] w_rpc_nxt;
  logic [CW-1:0]   w_inflight_nxt;
  logic [CW-1:0]   w_discard_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic [PW-1:0]   w_wptr_nxt;
  logic [PW-1:0]   w_rptr_nxt;
  entry_t          w_head;

  // Request credit: a redirecting cycle flushes the queue, so its entries
  // no longer hold credit; outstanding requests always do.
  always_comb begin
    w_occ       = i_redirect ? '0 : r_count;
    w_used      = {1'b0, w_occ} + {1'b0, r_inflight};
    o_imem_req  = (w_used < (CW+1)'(DEPTH));
    o_imem_addr = i_redirect ? i_redirect_pc : r_fpc;
  end

  // Handshake qualifiers; a response with nothing outstanding is spurious.
  always_comb begin
    w_gnt   = o_imem_req & i_imem_gnt;
    w_rsp   = i_imem_rvalid & (r_inflight != '0);
    w_push  = w_rsp & (r_discard == '0) & ~i_redirect;
    o_valid = (r_count != '0) & ~i_redirect;
    w_pop   = o_valid & i_ready;
  end

  // Head of queue shown combinationally.
  always_comb begin
    w_head    = r_mem[r_rptr];
    o_instr   = w_head.instr;
    o_pc      = w_head.pc;
    o_pc_four = w_head.pc + PC_STEP;
  end

  // Next-state for fetch/response bookkeeping and queue pointers.
  always_comb begin
    w_fpc_nxt      = r_fpc;
    w_rpc_nxt      = r_rpc;
    w_inflight_nxt = r_inflight + CW'(w_gnt) - CW'(w_rsp);
    w_discard_nxt  = r_discard;
    w_count_nxt    = r_count + CW'(w_push) - CW'(w_pop);
    w_wptr_nxt     = w_push ? (r_wptr + PW'(1)) : r_wptr;
    w_rptr_nxt     = w_pop  ? (r_rptr + PW'(1)) : r_rptr;

    if (w_gnt) begin
      w_fpc_nxt = o_imem_addr + PC_STEP;
    end else if (i_redirect) begin
      w_fpc_nxt = i_redirect_pc;
    end

    if (i_redirect) begin
      // Everything still outstanding after this cycle's response is stale.
      w_discard_nxt = r_inflight - CW'(w_rsp);
      w_rpc_nxt     = i_redirect_pc;
      w_count_nxt   = '0;
      w_wptr_nxt    = '0;
      w_rptr_nxt    = '0;
    end else begin
      if (w_rsp && (r_discard != '0)) begin
        w_discard_nxt = r_discard - CW'(1);
      end
      if (w_push) begin
        w_rpc_nxt = r_rpc + PC_STEP;
      end
    end
  end

  // Control state register.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_fpc      <= RESET_PC;
      r_rpc      <= RESET_PC;
      r_inflight <= '0;
      r_discard  <= '0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_fpc      <= w_fpc_nxt;
      r_rpc      <= w_rpc_nxt;
      r_inflight <= w_inflight_nxt;
      r_discard  <= w_discard_nxt;
      r_count    <= w_count_nxt;
      r_wptr     <= w_wptr_nxt;
      r_rptr     <= w_rptr_nxt;
    end
  end

  // Queue storage; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (i_reset && w_push) begin
      r_mem[r_wptr] <= '{pc: r_rpc, instr: i_imem_rdata};
    end
  end

endmodule

// File: tb/tb_stageif_pf.sv
// Directed bench for stageif_pf with a small in-order instruction memory.
module tb_stageif_pf;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic [31:0] o_pc_four;

  int total = 0;
  int bad   = 0;

  // Memory model controls
  logic        mem_hold = 1'b0;
  logic        spur     = 1'b0;
  logic [31:0] q_addr[$];
  int          q_rdy[$];
  int          mem_cyc  = 0;
  logic        m_rv;
  logic [31:0] m_rd;

  stageif_pf #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_instr(o_instr), .o_pc(o_pc), .o_pc_four(o_pc_four)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // In-order memory, one-cycle response latency, optional hold and spurious beat.
  always @(posedge i_clk) begin
    m_rv = 1'b0;
    m_rd = '0;
    if (!i_reset) begin
      q_addr.delete();
      q_rdy.delete();
    end else begin
      if (o_imem_req && i_imem_gnt) begin
        q_addr.push_back(o_imem_addr);
        q_rdy.push_back(mem_cyc);
      end
      if (!mem_hold && q_addr.size() > 0 && q_rdy[0] <= mem_cyc) begin
        m_rv = 1'b1;
        m_rd = mem_data(q_addr[0]);
        void'(q_addr.pop_front());
        void'(q_rdy.pop_front());
      end else if (spur) begin
        m_rv = 1'b1;
        m_rd = 32'h1234_5678;
      end
    end
    mem_cyc = mem_cyc + 1;
    i_imem_rvalid <= m_rv;
    i_imem_rdata  <= m_rd;
  end

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset       = 1'b0;
    i_redirect    = 1'b0;
    i_redirect_pc = '0;
    i_imem_gnt    = 1'b0;
    i_ready       = 1'b0;
    mem_hold      = 1'b0;
    spur          = 1'b0;
    tick();
    tick();
    i_reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    total++; if (o_imem_req !== 1'b1) begin bad++; $display("FAIL reset_req: got %b want 1", o_imem_req); end
    total++; if (o_imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 00000000", o_imem_addr); end
  endtask

  task automatic test_stream();
    do_reset();
    i_imem_gnt = 1'b1;
    i_ready    = 1'b1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL stream_fill0: got %b want 0", o_valid); end
    tick();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL stream_fill1: got %b want 0", o_valid); end
    tick();
    for (int k = 0; k < 8; k++) begin
      total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d]: got %b want 1", k, o_valid); end
      total++; if (o_pc !== 32'(4*k)) begin bad++; $display("FAIL stream_pc[%0d]: got %h want %h", k, o_pc, 32'(4*k)); end
      total++; if (o_instr !== mem_data(32'(4*k))) begin bad++; $display("FAIL stream_instr[%0d]: got %h want %h", k, o_instr, mem_data(32'(4*k))); end
      total++; if (o_pc_four !== 32'(4*k+4)) begin bad++; $display("FAIL stream_pc4[%0d]: got %h want %h", k, o_pc_four, 32'(4*k+4)); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    i_imem_gnt = 1'b1;
    i_ready    = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    total++; if (o_imem_req !== 1'b0) begin bad++; $display("FAIL bp_req_low: got %b want 0", o_imem_req); end
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1", o_valid); end
    total++; if (o_pc !== 32'h0) begin bad++; $display("FAIL bp_head: got %h want 00000000", o_pc); end
    i_imem_gnt = 1'b0;
    i_ready    = 1'b1;
    #1;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (o_valid) begin
        total++; if (o_pc !== 32'(4*n)) begin bad++; $display("FAIL bp_pc[%0d]: got %h want %h", n, o_pc, 32'(4*n)); end
        total++; if (o_instr !== mem_data(32'(4*n))) begin bad++; $display("FAIL bp_instr[%0d]: got %h want %h", n, o_instr, mem_data(32'(4*n))); end
        n++;
      end
      tick();
    end
    total++; if (n !== 4) begin bad++; $display("FAIL bp_count: got %0d want 4", n); end
  endtask

  task automatic test_redirect_inflight();
    logic found;
    do_reset();
    i_ready    = 1'b1;
    mem_hold   = 1'b1;
    i_imem_gnt = 1'b1;
    tick();
    tick();
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h100;
    #1;
    total++; if (o_imem_addr !== 32'h100) begin bad++; $display("FAIL rd_addr: got %h want 00000100", o_imem_addr); end
    total++; if (o_imem_req !== 1'b1) begin bad++; $display("FAIL rd_req: got %b want 1", o_imem_req); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rd_valid: got %b want 0", o_valid); end
    tick();
    i_redirect = 1'b0;
    mem_hold   = 1'b0;
    #1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (o_valid) found = 1'b1;
      else tick();
    end
    total++; if (!found) begin bad++; $display("FAIL rd_timeout: got no valid want valid"); end
    if (found) begin
      total++; if (o_pc !== 32'h100) begin bad++; $display("FAIL rd_first_pc: got %h want 00000100", o_pc); end
      total++; if (o_instr !== mem_data(32'h100)) begin bad++; $display("FAIL rd_first_instr: got %h want %h", o_instr, mem_data(32'h100)); end
      tick();
      total++; if (o_pc !== 32'h104 || o_valid !== 1'b1) begin bad++; $display("FAIL rd_second_pc: got %h/%b want 00000104/1", o_pc, o_valid); end
    end
  endtask

  task automatic test_redirect_collide();
    do_reset();
    i_imem_gnt = 1'b1;
    i_ready    = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    total++; if (o_valid !== 1'b1 || o_pc !== 32'h8) begin bad++; $display("FAIL col_pre: got %b/%h want 1/00000008", o_valid, o_pc); end
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h200;
    #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL col_valid_redirect: got %b want 0", o_valid); end
    tick();
    i_redirect = 1'b0;
    #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL col_valid_after: got %b want 0", o_valid); end
    tick();
    total++; if (o_valid !== 1'b1 || o_pc !== 32'h200) begin bad++; $display("FAIL col_new_pc: got %b/%h want 1/00000200", o_valid, o_pc); end
    total++; if (o_instr !== mem_data(32'h200)) begin bad++; $display("FAIL col_new_instr: got %h want %h", o_instr, mem_data(32'h200)); end
    tick();
    total++; if (o_valid !== 1'b1 || o_pc !== 32'h204) begin bad++; $display("FAIL col_next_pc: got %b/%h want 1/00000204", o_valid, o_pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    i_imem_gnt = 1'b1;
    i_ready    = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    i_redirect    = 1'b1;
    i_redirect_pc = 32'hFFFF_FFFC;
    tick();
    i_redirect = 1'b0;
    #1;
    total++; if (o_imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_fetch_addr: got %h want 00000000", o_imem_addr); end
    tick();
    total++; if (o_valid !== 1'b1 || o_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc: got %b/%h want 1/fffffffc", o_valid, o_pc); end
    total++; if (o_pc_four !== 32'h0) begin bad++; $display("FAIL wrap_pc4: got %h want 00000000", o_pc_four); end
    tick();
    total++; if (o_valid !== 1'b1 || o_pc !== 32'h0) begin bad++; $display("FAIL wrap_next_pc: got %b/%h want 1/00000000", o_valid, o_pc); end
    total++; if (o_pc_four !== 32'h4) begin bad++; $display("FAIL wrap_next_pc4: got %h want 00000004", o_pc_four); end
  endtask

  task automatic test_spurious();
    do_reset();
    i_ready = 1'b1;
    spur    = 1'b1;
    tick();
    spur = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL spur_valid: got %b want 0", o_valid); end
    total++; if (o_imem_addr !== 32'h0) begin bad++; $display("FAIL spur_addr: got %h want 00000000", o_imem_addr); end
    i_imem_gnt = 1'b1;
    tick();
    tick();
    total++; if (o_valid !== 1'b1 || o_pc !== 32'h0) begin bad++; $display("FAIL spur_first_pc: got %b/%h want 1/00000000", o_valid, o_pc); end
    total++; if (o_instr !== mem_data(32'h0)) begin bad++; $display("FAIL spur_first_instr: got %h want %h", o_instr, mem_data(32'h0)); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    i_imem_gnt = 1'b1;
    i_ready    = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    total++; if (o_valid !== 1'b1 || o_imem_req !== 1'b0) begin bad++; $display("FAIL mid_full: got %b/%b want 1/0", o_valid, o_imem_req); end
    i_reset = 1'b0;
    tick();
    i_reset = 1'b1;
    #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", o_valid); end
    total++; if (o_imem_addr !== 32'h0) begin bad++; $display("FAIL mid_addr: got %h want 00000000", o_imem_addr); end
    total++; if (o_imem_req !== 1'b1) begin bad++; $display("FAIL mid_req: got %b want 1", o_imem_req); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_collide();
    test_wrap();
    test_spurious();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
